// File: rtl/hex7seg_pkg.sv
// hex7seg_pkg: segment code table, idle patterns and receiver state encodings
package hex7seg_pkg;
    localparam logic [15:0][6:0] SEG_CODE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_NONE = 4'hF;
    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: active-low seven-segment pattern to hex nibble, code_ok low on unknown patterns
module seg7_decode
    import hex7seg_pkg::*;
(
    input  logic [6:0] a_to_g,
    output logic [3:0] nibble,
    output logic       code_ok
);
    // table lookup; an unknown pattern leaves nibble 0 and code_ok low
    always_comb begin
        nibble = 4'd0;
        code_ok = 1'b0;
        for (int i = 0; i < 16; i++)
            if (a_to_g == SEG_CODE[i]) begin
                nibble = 4'(i);
                code_ok = 1'b1;
            end
    end
endmodule

// File: rtl/hex7seg_rx.sv
// hex7seg_rx: multiplexed seven-segment bus receiver; HEX7SEG_RX_SYNC_EN adds a 2-flop input synchronizer
module hex7seg_rx
    import hex7seg_pkg::*;
#(
    parameter int STABLE_CYC = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        cclk,
    input  logic        clr_n,
    input  logic [6:0]  a_to_g,
    input  logic [7:0]  an,
    input  logic        dp,
    output logic [15:0] x,
    output logic [3:0]  blank,
    output logic        valid,
    output logic        frame_err,
    output logic        locked
);
    localparam logic [3:0] SC = 4'(STABLE_CYC);
    localparam logic [15:0] TC = 16'(TIMEOUT_CYC - 1);
    localparam logic [11:0] IDLE = {AN_NONE, SEG_BLANK, 1'b1};

    logic [11:0] din, smp;
    logic [3:0] run, low, seen, nib;
    logic [1:0] k;
    logic [15:0] acc, tcnt;
    logic hit, ok, one, multi, digit, dig0, bad, lead, err, unused_an;
    logic [0:0] st;

    assign unused_an = ^an[7:4];

`ifdef HEX7SEG_RX_SYNC_EN
    logic [11:0] s1, s2;
    // two-flop synchronizer for a bus driven from another clock domain
    always_ff @(posedge cclk or negedge clr_n) begin
        if (!clr_n) begin
            s1 <= IDLE;
            s2 <= IDLE;
        end else begin
            s1 <= {an[3:0], a_to_g, dp};
            s2 <= s1;
        end
    end
    assign din = s2;
`else
    assign din = {an[3:0], a_to_g, dp};
`endif

    // register the bus and accept a slot once, when its run reaches STABLE_CYC
    always_ff @(posedge cclk or negedge clr_n) begin
        if (!clr_n) begin
            smp <= IDLE;
            run <= 4'd0;
            hit <= 1'b0;
        end else begin
            smp <= din;
            run <= din != smp ? 4'd1 : run < SC ? run + 4'd1 : run;
            hit <= din != smp ? SC == 4'd1 : run + 4'd1 == SC;
        end
    end

    seg7_decode u_dec (.a_to_g(smp[7:1]), .nibble(nib), .code_ok(ok));

    assign low = ~smp[11:8];
    assign one = low != 4'd0 && (low & (low - 4'd1)) == 4'd0;
    assign multi = hit && low != 4'd0 && !one;
    assign digit = hit && one;
    assign dig0 = digit && low[0];
    assign k = low[3] ? 2'd3 : low[2] ? 2'd2 : low[1] ? 2'd1 : 2'd0;
    assign bad = !ok || !smp[0];
    assign lead = (seen[2] && !seen[1]) || (seen[3] && !(seen[1] && seen[2]));

    // frame assembly: hunt for digit 0, collect digits, publish on the next digit 0
    always_ff @(posedge cclk or negedge clr_n) begin
        if (!clr_n) begin
            st <= ST_HUNT;
            acc <= 16'd0;
            seen <= 4'd0;
            err <= 1'b0;
            tcnt <= 16'd0;
            x <= 16'd0;
            blank <= 4'd0;
            valid <= 1'b0;
            frame_err <= 1'b0;
            locked <= 1'b0;
        end else begin
            valid <= 1'b0;
            tcnt <= hit ? 16'd0 : tcnt + 16'd1;
            if (!hit && tcnt == TC) begin
                tcnt <= 16'd0;
                locked <= 1'b0;
                st <= ST_HUNT;
            end else if (st == ST_HUNT) begin
                if (dig0) begin
                    acc <= {12'd0, nib};
                    seen <= 4'b0001;
                    err <= bad;
                    st <= ST_COLLECT;
                end
            end else if (dig0) begin
                x <= acc & {{4{seen[3]}}, {4{seen[2]}}, {4{seen[1]}}, {4{seen[0]}}};
                blank <= ~seen & 4'b1110;
                frame_err <= err || lead;
                valid <= 1'b1;
                locked <= 1'b1;
                acc <= {12'd0, nib};
                seen <= 4'b0001;
                err <= bad;
            end else if (digit) begin
                acc[{k, 2'b00} +: 4] <= nib;
                seen[k] <= 1'b1;
                err <= err || bad || seen[k];
            end else if (multi) begin
                err <= 1'b1;
            end
        end
    end
endmodule
